// File: rtl/pio_pkg.sv
// Shared constants for the multi-port parallel I/O peripheral:
// bus data width and the per-port register offsets.
package pio_pkg;

  localparam int BUS_W = 8;

  typedef logic [BUS_W-1:0] bus_data_t;
  typedef logic [1:0]       reg_off_t;

  localparam reg_off_t REG_DATA = 2'd0;
  localparam reg_off_t REG_DIR  = 2'd1;
  localparam reg_off_t REG_IEN  = 2'd2;
  localparam reg_off_t REG_STAT = 2'd3;

endpackage

// File: rtl/pio_port.sv
// One parallel I/O port: output latch, direction, interrupt enable/status,
// two-flop input synchroniser and pin-change edge detection.
module pio_port
  import pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int IRQ_RISING_ONLY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       offset,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] pin_oe,
  input  logic [WIDTH-1:0] pin_i,
  output logic             irq_req
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] ien_q;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_mask;

  always_comb begin
    if (IRQ_RISING_ONLY != 0) edge_hit = sync2 & ~prev_q;
    else                      edge_hit = sync2 ^ prev_q;
  end

  always_comb begin
    clr_mask = '0;
    if (wr_en && offset == REG_STAT) clr_mask = wdata[WIDTH-1:0];
  end

  // The set term is OR-ed in after the clear, so a new edge beats a
  // write-1-to-clear landing on the same bit in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      dir_q  <= '0;
      ien_q  <= '0;
      stat_q <= '0;
      sync1  <= '0;
      sync2  <= '0;
      prev_q <= '0;
    end else begin
      sync1  <= pin_i;
      sync2  <= sync1;
      prev_q <= sync2;
      stat_q <= (stat_q & ~clr_mask) | (edge_hit & ien_q);
      if (wr_en) begin
        case (offset)
          REG_DATA: data_q <= wdata[WIDTH-1:0];
          REG_DIR:  dir_q  <= wdata[WIDTH-1:0];
          REG_IEN:  ien_q  <= wdata[WIDTH-1:0];
          default:  ;
        endcase
      end
    end
  end

  // DATA reads return the synchronised pin, not the output latch.
  always_comb begin
    rdata = '0;
    case (offset)
      REG_DATA: rdata[WIDTH-1:0] = sync2;
      REG_DIR:  rdata[WIDTH-1:0] = dir_q;
      REG_IEN:  rdata[WIDTH-1:0] = ien_q;
      default:  rdata[WIDTH-1:0] = stat_q;
    endcase
  end

  assign pin_o   = data_q;
  assign pin_oe  = dir_q;
  assign irq_req = |(stat_q & ien_q);

endmodule

// File: rtl/pio_multi.sv
// Multi-port PIO top: CPU bus strobe edge detection, port decode,
// registered read mux and the combined level interrupt.
module pio_multi
  import pio_pkg::*;
#(
  parameter int NPORTS          = 2,
  parameter int WIDTH           = 8,
  parameter int IRQ_RISING_ONLY = 0,
  parameter int ADDR_W          = $clog2(NPORTS) + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cs_n,
  input  logic                    we_n,
  input  logic                    oe_n,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [BUS_W-1:0]        data_tx,
  output logic [BUS_W-1:0]        data_rx,
  output logic [NPORTS*WIDTH-1:0] port_o,
  output logic [NPORTS*WIDTH-1:0] port_oe,
  input  logic [NPORTS*WIDTH-1:0] port_i,
  output logic                    irq
);

  // Bus protocol: a write commits once on the leading edge of (!cs_n & !we_n);
  // a read (!cs_n & !oe_n) returns data one cycle later; write wins over read.
  logic              wr;
  logic              wr_prev;
  logic              wr_pulse;
  logic              rd;
  logic              addr_ok;
  logic [ADDR_W-1:0] port_sel;
  logic [1:0]        offset;
  logic [BUS_W-1:0]  rd_mux;
  logic [BUS_W-1:0]  port_rdata [NPORTS];
  logic [NPORTS-1:0] port_irq;

  assign wr       = !cs_n && !we_n;
  assign rd       = !cs_n && !oe_n && !wr;
  assign wr_pulse = wr && !wr_prev;
  assign port_sel = addr >> 2;
  assign offset   = addr[1:0];
  assign addr_ok  = port_sel < ADDR_W'(NPORTS);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    pio_port #(
      .WIDTH           (WIDTH),
      .IRQ_RISING_ONLY (IRQ_RISING_ONLY)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_pulse && addr_ok && port_sel == ADDR_W'(p)),
      .offset  (offset),
      .wdata   (data_tx),
      .rdata   (port_rdata[p]),
      .pin_o   (port_o[p*WIDTH +: WIDTH]),
      .pin_oe  (port_oe[p*WIDTH +: WIDTH]),
      .pin_i   (port_i[p*WIDTH +: WIDTH]),
      .irq_req (port_irq[p])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_sel == ADDR_W'(p)) rd_mux = port_rdata[p];
    end
  end

  // wr_prev comes out of reset set, so a strobe still held across reset
  // must be released and re-asserted before it can commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev <= 1'b1;
      data_rx <= '0;
      irq     <= 1'b0;
    end else begin
      wr_prev <= wr;
      data_rx <= (rd && addr_ok) ? rd_mux : '0;
      irq     <= |port_irq;
    end
  end

endmodule
